// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the stream round-robin arbiter.
// Holds the output-stage state encoding and default widths.
package stream_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    localparam int unsigned DEF_DW  = 16;
    localparam int unsigned DEF_N   = 4;
    localparam int unsigned STALL_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr (wrapping modulo N) wins; gnt is one-hot, or all-zero when nothing is requested.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx
);

    logic        found;
    int unsigned j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            // ptr is always below N, so a single subtraction wraps the index
            j = i + 32'(ptr);
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found      = 1'b1;
                gnt[j]     = 1'b1;
                gnt_idx    = SW'(j);
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-to-1 stream arbiter: round-robin selection feeding a one-entry registered
// output stage, with a saturating counter of sink-stalled cycles.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned N  = DEF_N,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        in_valid,
    input  logic [N*DW-1:0]     in_data,
    output logic [N-1:0]        in_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic [SW-1:0]       out_src,
    input  logic                out_ready,
    output logic [STALL_W-1:0]  stall_cnt
);

    out_state_e         state_q, state_d;
    logic [SW-1:0]      ptr_q, ptr_d;
    logic [DW-1:0]      data_q, data_d;
    logic [SW-1:0]      src_q, src_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic [N-1:0]       gnt;
    logic [SW-1:0]      gnt_idx;
    logic               slot_free;
    logic               accept;
    logic [DW-1:0]      win_data;

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) begin
                win_data = in_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        src_d     = src_q;
        stall_d   = stall_q;
        slot_free = (state_q == EMPTY) || out_ready;
        // rst gates the grant so in_ready is low during reset regardless of in_valid
        accept    = slot_free && (|in_valid) && !rst;
        in_ready  = accept ? gnt : '0;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (!out_ready) begin
                    if (stall_q != '1) begin
                        stall_d = stall_q + 1'b1;
                    end
                end else if (!accept) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (accept) begin
            data_d = win_data;
            src_d  = gnt_idx;
            ptr_d  = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            src_q   <= src_d;
            stall_q <= stall_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter (DW=16, N=4): each task drives one
// scenario and compares outputs against hand-derived values.
module tb_stream_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_src;
    logic        out_ready;
    logic [15:0] stall_cnt;

    int vectors;
    int miscompares;

    stream_rr_arbiter #(
        .DW (16),
        .N  (4),
        .SW (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%0h exp=0", out_valid); end
        vectors++; if (out_data !== 16'h0) begin miscompares++; $display("FAIL rst_data got=%0h exp=0", out_data); end
        vectors++; if (out_src !== 2'd0) begin miscompares++; $display("FAIL rst_src got=%0h exp=0", out_src); end
        vectors++; if (stall_cnt !== 16'h0) begin miscompares++; $display("FAIL rst_stall got=%0h exp=0", stall_cnt); end
        vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
        drive_edge();
        rst      = 1'b0;
        in_valid = 4'b0000;
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_rdy;
        logic [1:0]  exp_src;
        logic [15:0] exp_d;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_rdy = 4'b0001 << (k % 4);
            vectors++; if (in_ready !== exp_rdy) begin miscompares++; $display("FAIL fair_in_ready[%0d] got=%b exp=%b", k, in_ready, exp_rdy); end
            if (k > 0) begin
                exp_src = 2'((k - 1) % 4);
                exp_d   = 16'h1111 * 16'(((k - 1) % 4) + 1);
                vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL fair_valid[%0d] got=%0h exp=1", k, out_valid); end
                vectors++; if (out_src !== exp_src) begin miscompares++; $display("FAIL fair_src[%0d] got=%0d exp=%0d", k, out_src, exp_src); end
                vectors++; if (out_data !== exp_d) begin miscompares++; $display("FAIL fair_data[%0d] got=%0h exp=%0h", k, out_data, exp_d); end
            end
            drive_edge();
        end
        in_valid = 4'b0000;
        @(negedge clk);
        vectors++; if (out_src !== 2'd3) begin miscompares++; $display("FAIL fair_last_src got=%0d exp=3", out_src); end
        vectors++; if (out_data !== 16'h4444) begin miscompares++; $display("FAIL fair_last_data got=%0h exp=4444", out_data); end
        vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL fair_idle_ready got=%b exp=0000", in_ready); end
        drive_edge();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fair_drain_valid got=%0h exp=0", out_valid); end
        drive_edge();
    endtask

    task automatic test_single();
        in_data[31:16] = 16'hA5A5;
        in_valid       = 4'b0010;
        out_ready      = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== 4'b0010) begin miscompares++; $display("FAIL single_in_ready got=%b exp=0010", in_ready); end
        drive_edge();
        in_valid = 4'b0000;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got=%0h exp=1", out_valid); end
        vectors++; if (out_data !== 16'hA5A5) begin miscompares++; $display("FAIL single_data got=%0h exp=a5a5", out_data); end
        vectors++; if (out_src !== 2'd1) begin miscompares++; $display("FAIL single_src got=%0d exp=1", out_src); end
        drive_edge();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got=%0h exp=0", out_valid); end
        drive_edge();
    endtask

    task automatic test_wrap();
        in_valid = 4'b0100;
        @(negedge clk);
        vectors++; if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL wrap_setup_ready got=%b exp=0100", in_ready); end
        drive_edge();
        in_valid = 4'b0101;
        @(negedge clk);
        vectors++; if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL wrap_first_ready got=%b exp=0001", in_ready); end
        drive_edge();
        @(negedge clk);
        vectors++; if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL wrap_second_ready got=%b exp=0100", in_ready); end
        vectors++; if (out_src !== 2'd0) begin miscompares++; $display("FAIL wrap_first_src got=%0d exp=0", out_src); end
        vectors++; if (out_data !== 16'h1111) begin miscompares++; $display("FAIL wrap_first_data got=%0h exp=1111", out_data); end
        drive_edge();
        in_valid = 4'b0000;
        @(negedge clk);
        vectors++; if (out_src !== 2'd2) begin miscompares++; $display("FAIL wrap_second_src got=%0d exp=2", out_src); end
        vectors++; if (out_data !== 16'h3333) begin miscompares++; $display("FAIL wrap_second_data got=%0h exp=3333", out_data); end
        drive_edge();
    endtask

    task automatic test_backpressure();
        logic        took;
        logic        prev_held;
        logic [15:0] prev_data;
        logic [15:0] last_stall;
        int          xfers;
        took       = 1'b0;
        prev_held  = 1'b0;
        prev_data  = '0;
        last_stall = '0;
        xfers      = 0;
        in_data[15:0] = 16'hB000;
        in_valid      = 4'b0001;
        for (int k = 0; k < 30; k++) begin
            out_ready = ((k % 5) == 4);
            if (took) in_data[15:0] = in_data[15:0] + 16'd1;
            @(negedge clk);
            vectors++; if ((in_ready & ~in_valid) !== 4'b0000) begin miscompares++; $display("FAIL bp_ready_no_valid[%0d] got=%b valid=%b", k, in_ready, in_valid); end
            if (prev_held) begin
                vectors++; if (out_data !== prev_data) begin miscompares++; $display("FAIL bp_stable[%0d] got=%0h exp=%0h", k, out_data, prev_data); end
            end
            if (out_valid && out_ready) begin
                vectors++; if (out_data !== 16'hB000 + 16'(xfers)) begin miscompares++; $display("FAIL bp_data[%0d] got=%0h exp=%0h", xfers, out_data, 16'hB000 + 16'(xfers)); end
                if (xfers == 0) begin
                    vectors++; if (stall_cnt !== 16'd3) begin miscompares++; $display("FAIL bp_first_stall got=%0d exp=3", stall_cnt); end
                end else begin
                    vectors++; if (stall_cnt - last_stall !== 16'd4) begin miscompares++; $display("FAIL bp_stall_delta[%0d] got=%0d exp=4", xfers, stall_cnt - last_stall); end
                end
                last_stall = stall_cnt;
                xfers++;
            end
            prev_held = out_valid && !out_ready;
            prev_data = out_data;
            took      = in_ready[0];
            drive_edge();
        end
        vectors++; if (xfers !== 6) begin miscompares++; $display("FAIL bp_xfer_count got=%0d exp=6", xfers); end
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        drive_edge();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got=%0h exp=0", out_valid); end
        vectors++; if (stall_cnt !== 16'd23) begin miscompares++; $display("FAIL bp_total_stall got=%0d exp=23", stall_cnt); end
        drive_edge();
    endtask

    task automatic test_saturation();
        in_data[31:16] = 16'hC3C3;
        in_valid       = 4'b0010;
        out_ready      = 1'b0;
        @(negedge clk);
        vectors++; if (in_ready !== 4'b0010) begin miscompares++; $display("FAIL sat_in_ready got=%b exp=0010", in_ready); end
        drive_edge();
        in_valid = 4'b0000;
        repeat (100) @(posedge clk);
        @(negedge clk);
        vectors++; if (stall_cnt !== 16'd123) begin miscompares++; $display("FAIL sat_partial got=%0d exp=123", stall_cnt); end
        vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL sat_ready_low got=%b exp=0000", in_ready); end
        repeat (70000) @(posedge clk);
        @(negedge clk);
        vectors++; if (stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reached got=%0h exp=ffff", stall_cnt); end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sat_valid got=%0h exp=1", out_valid); end
        vectors++; if (out_data !== 16'hC3C3) begin miscompares++; $display("FAIL sat_data got=%0h exp=c3c3", out_data); end
        vectors++; if (out_src !== 2'd1) begin miscompares++; $display("FAIL sat_src got=%0d exp=1", out_src); end
        repeat (5) @(posedge clk);
        @(negedge clk);
        vectors++; if (stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got=%0h exp=ffff", stall_cnt); end
        drive_edge();
    endtask

    task automatic test_reset_mid();
        in_valid = 4'b1111;
        #1;
        rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got=%0h exp=0", out_valid); end
        vectors++; if (out_data !== 16'h0) begin miscompares++; $display("FAIL mid_rst_data got=%0h exp=0", out_data); end
        vectors++; if (stall_cnt !== 16'h0) begin miscompares++; $display("FAIL mid_rst_stall got=%0h exp=0", stall_cnt); end
        vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_ready got=%b exp=0000", in_ready); end
        drive_edge();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b0110;
        #2;
        vectors++; if (in_ready !== 4'b0010) begin miscompares++; $display("FAIL mid_ptr_zero got=%b exp=0010", in_ready); end
        in_valid = 4'b1000;
        #1;
        vectors++; if (in_ready !== 4'b1000) begin miscompares++; $display("FAIL mid_req3_ready got=%b exp=1000", in_ready); end
        drive_edge();
        in_valid = 4'b1111;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_valid got=%0h exp=1", out_valid); end
        vectors++; if (out_src !== 2'd3) begin miscompares++; $display("FAIL mid_src got=%0d exp=3", out_src); end
        vectors++; if (out_data !== 16'h4444) begin miscompares++; $display("FAIL mid_data got=%0h exp=4444", out_data); end
        vectors++; if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_next_ready got=%b exp=0001", in_ready); end
        drive_edge();
        in_valid = 4'b0000;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_fairness();
        test_single();
        test_wrap();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
